rob: RTL

ROB -- requirements
Module: rob

---
 rtl/rob_if.sv | 59 +++++
 rtl/rob.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rob_if.sv
// Reorder-buffer bus: dispatch, result broadcasts, operand lookups and commit/flush outputs.
// The ROB itself sits on the slave side; the decoder/execution units sit on the master side.
interface rob_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 rob_full;
    logic [ROB_WIDTH-1:0] next_rob_id;

    logic                 dec_ready;
    logic [1:0]           dec_type;
    logic [4:0]           dec_rd;
    logic                 dec_done;
    logic [31:0]          dec_value;

    logic                 rs_ready;
    logic [ROB_WIDTH-1:0] rs_rob_id;
    logic [31:0]          rs_value;
    logic                 lsb_ready;
    logic [ROB_WIDTH-1:0] lsb_rob_id;
    logic [31:0]          lsb_value;

    logic [ROB_WIDTH-1:0] qj_id;
    logic [ROB_WIDTH-1:0] qk_id;
    logic                 qj_ready;
    logic                 qk_ready;
    logic [31:0]          qj_value;
    logic [31:0]          qk_value;

    logic                 commit_valid;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_value;
    logic                 commit_store;
    logic                 clear;
    logic [31:0]          clear_pc;
    logic                 halt;

    modport master (
        output dec_ready, dec_type, dec_rd, dec_done, dec_value,
        output rs_ready, rs_rob_id, rs_value,
        output lsb_ready, lsb_rob_id, lsb_value,
        output qj_id, qk_id,
        input  rob_full, next_rob_id,
        input  qj_ready, qk_ready, qj_value, qk_value,
        input  commit_valid, commit_rob_id, commit_rd, commit_value, commit_store,
        input  clear, clear_pc, halt
    );

    modport slave (
        input  dec_ready, dec_type, dec_rd, dec_done, dec_value,
        input  rs_ready, rs_rob_id, rs_value,
        input  lsb_ready, lsb_rob_id, lsb_value,
        input  qj_id, qk_id,
        output rob_full, next_rob_id,
        output qj_ready, qk_ready, qj_value, qk_value,
        output commit_valid, commit_rob_id, commit_rd, commit_value, commit_store,
        output clear, clear_pc, halt
    );
endinterface

// File: rtl/rob.sv
// Reorder buffer: 2^ROB_WIDTH-entry circular queue with in-order commit, broadcast capture,
// operand lookup with same-cycle bypass, branch-mispredict flush and sticky halt on exit.
module rob #(
    parameter int ROB_WIDTH = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    rob_if.slave bus
);
    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_STORE  = 2'd2,
        T_EXIT   = 2'd3
    } entry_type_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;
    logic [ROB_SIZE-1:0]  r_busy;
    logic [ROB_SIZE-1:0]  r_ready;
    entry_type_t          r_type  [ROB_SIZE];
    logic [4:0]           r_rd    [ROB_SIZE];
    logic [31:0]          r_value [ROB_SIZE];
    logic [31:0]          r_pred  [ROB_SIZE];

    logic                 r_commit_valid;
    logic                 r_commit_store;
    logic [ROB_WIDTH-1:0] r_commit_rob_id;
    logic [4:0]           r_commit_rd;
    logic [31:0]          r_commit_value;
    logic                 r_clear;
    logic [31:0]          r_clear_pc;

    logic                 w_full;
    logic                 w_dispatch;
    logic                 w_commit;
    logic                 w_mispredict;
    logic                 w_exit;
    logic                 w_rs_hit;
    logic                 w_lsb_hit;

    // Busy entries are exactly head..tail-1, so the busy check also rejects a broadcast
    // aimed at the tag being dispatched this cycle.
    always_comb begin
        w_full       = (r_count == (ROB_WIDTH+1)'(ROB_SIZE));
        w_dispatch   = rdy_in && bus.dec_ready && !w_full;
        w_commit     = rdy_in && (r_state == ST_RUN) && r_busy[r_head] && r_ready[r_head];
        w_mispredict = w_commit && (r_type[r_head] == T_BRANCH)
                       && (r_value[r_head] != r_pred[r_head]);
        w_exit       = w_commit && (r_type[r_head] == T_EXIT);
        w_rs_hit     = bus.rs_ready && r_busy[bus.rs_rob_id];
        w_lsb_hit    = bus.lsb_ready && r_busy[bus.lsb_rob_id];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_RUN;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_exit) w_state_next = ST_HALT;
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                r_type[i]  <= T_REG;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
                r_pred[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (w_mispredict) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_busy  <= '0;
                r_ready <= '0;
            end else begin
                if (w_rs_hit) begin
                    r_ready[bus.rs_rob_id] <= 1'b1;
                    r_value[bus.rs_rob_id] <= bus.rs_value;
                end
                if (w_lsb_hit) begin
                    r_ready[bus.lsb_rob_id] <= 1'b1;
                    r_value[bus.lsb_rob_id] <= bus.lsb_value;
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + ROB_WIDTH'(1);
                end
                if (w_dispatch) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= bus.dec_done;
                    r_type[r_tail]  <= entry_type_t'(bus.dec_type);
                    r_rd[r_tail]    <= bus.dec_rd;
                    r_value[r_tail] <= bus.dec_done ? bus.dec_value : 32'd0;
                    r_pred[r_tail]  <= bus.dec_value;
                    r_tail          <= r_tail + ROB_WIDTH'(1);
                end
                r_count <= r_count + (ROB_WIDTH+1)'(w_dispatch) - (ROB_WIDTH+1)'(w_commit);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_commit_valid  <= 1'b0;
            r_commit_store  <= 1'b0;
            r_commit_rob_id <= '0;
            r_commit_rd     <= '0;
            r_commit_value  <= '0;
            r_clear         <= 1'b0;
            r_clear_pc      <= '0;
        end else if (rdy_in) begin
            r_commit_valid <= w_commit;
            r_commit_store <= w_commit && (r_type[r_head] == T_STORE);
            r_clear        <= w_mispredict;
            if (w_commit) begin
                r_commit_rob_id <= r_head;
                r_commit_rd     <= (r_type[r_head] == T_REG) ? r_rd[r_head] : 5'd0;
                r_commit_value  <= r_value[r_head];
            end
            if (w_mispredict) begin
                r_clear_pc <= r_value[r_head];
            end
        end
    end

    // Operand lookup: a broadcast in flight this cycle wins over stored state, rs over lsb.
    always_comb begin
        bus.qj_ready = 1'b0;
        bus.qj_value = '0;
        bus.qk_ready = 1'b0;
        bus.qk_value = '0;
        if (bus.rs_ready && (bus.rs_rob_id == bus.qj_id)) begin
            bus.qj_ready = 1'b1;
            bus.qj_value = bus.rs_value;
        end else if (bus.lsb_ready && (bus.lsb_rob_id == bus.qj_id)) begin
            bus.qj_ready = 1'b1;
            bus.qj_value = bus.lsb_value;
        end else if (r_ready[bus.qj_id]) begin
            bus.qj_ready = 1'b1;
            bus.qj_value = r_value[bus.qj_id];
        end
        if (bus.rs_ready && (bus.rs_rob_id == bus.qk_id)) begin
            bus.qk_ready = 1'b1;
            bus.qk_value = bus.rs_value;
        end else if (bus.lsb_ready && (bus.lsb_rob_id == bus.qk_id)) begin
            bus.qk_ready = 1'b1;
            bus.qk_value = bus.lsb_value;
        end else if (r_ready[bus.qk_id]) begin
            bus.qk_ready = 1'b1;
            bus.qk_value = r_value[bus.qk_id];
        end
    end

    assign bus.rob_full      = w_full;
    assign bus.next_rob_id   = r_tail;
    assign bus.commit_valid  = r_commit_valid;
    assign bus.commit_store  = r_commit_store;
    assign bus.commit_rob_id = r_commit_rob_id;
    assign bus.commit_rd     = r_commit_rd;
    assign bus.commit_value  = r_commit_value;
    assign bus.clear         = r_clear;
    assign bus.clear_pc      = r_clear_pc;
    assign bus.halt          = (r_state == ST_HALT);
endmodule
